// File: rtl/core_fetch.sv
`default_nettype none
// ============================================================================
// Module      : core_fetch
// Description : Instruction fetch unit for the 16-bit core. Issues halfword
//               fetches to the instruction memory port, buffers returned
//               halfwords in a small prefetch FIFO and presents one
//               {insn, insn_pc} pair per cycle to decode. Emits NOP (16'h0000)
//               whenever no instruction is available. Honours decode stall
//               and the pipeline flush redirect.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH      prefetch FIFO entries (power of two, >= 2)
//   PC_W       halfword pointer width
//   RESET_PC   first fetch address after reset
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   stall      decode stalled; insn / insn_pc held
//   flush      redirect; drop all prefetched and in-flight state
//   target     redirect PC, valid with flush
//   insn       instruction to decode
//   insn_pc    PC of insn
//   mem_req    fetch request (held until mem_ack)
//   mem_addr   halfword address of the request
//   mem_ack    request completed, mem_data valid this cycle
//   mem_data   fetched halfword
// Build option
//   CORE_FETCH_BYPASS_EN  when defined, a response arriving while the FIFO is
//                         empty and decode is not stalled is loaded straight
//                         into insn / insn_pc, saving one cycle of latency.
// ============================================================================
module core_fetch #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic [PC_W-1:0] target,
    output logic [15:0]     insn,
    output logic [PC_W-1:0] insn_pc,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [15:0]     mem_data
);

    localparam int            c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0] c_DEPTH = DEPTH[c_AW:0];
    localparam logic [15:0]   c_NOP   = 16'h0000;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PC_W-1:0] r_fetch_pc;     // next address to request
    logic [PC_W-1:0] r_mem_addr;     // address of the current / last request
    logic            r_pending;      // a request is outstanding (drives mem_req)
    logic            r_discard;      // outstanding response belongs to a flushed stream
    logic [15:0]     r_insn;
    logic [PC_W-1:0] r_insn_pc;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_AW:0]   r_wptr;
    logic [c_AW:0]   r_rptr;
    logic [PC_W-1:0] r_fifo_pc   [DEPTH];
    logic [15:0]     r_fifo_insn [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic            w_empty;
    logic            w_full;
    logic            w_ack;          // ack for a request we actually issued
    logic            w_ack_keep;     // ack whose data belongs to the live stream
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic [c_AW:0]   w_occ;
    logic [c_AW:0]   w_occ_next;
    logic [PC_W-1:0] w_fetch_pc_next;
    logic            w_issue;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);

    // An ack while no request is outstanding is illegal and ignored.
    assign w_ack      = r_pending && mem_ack;
    assign w_ack_keep = w_ack && !r_discard;

`ifdef CORE_FETCH_BYPASS_EN
    assign w_bypass = w_ack_keep && w_empty && !stall && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // Flush wins over everything, so neither push nor pop happens then.
    // The full guard never blocks in practice because each outstanding
    // request already owns a free slot.
    assign w_push = rst_n && !flush && w_ack_keep && !w_bypass && (!w_full || w_pop);
    assign w_pop  = rst_n && !flush && !stall && !w_empty;

    // Occupancy after this edge; a new request may only be issued if it
    // still leaves room for its own response.
    assign w_occ      = r_wptr - r_rptr;
    assign w_occ_next = w_occ + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};

    // The fetch PC advances only for responses that are kept (FIFO or bypass).
    assign w_fetch_pc_next = w_ack_keep ? (r_fetch_pc + PC_W'(1)) : r_fetch_pc;

    // Only one request may be outstanding: issue when idle, or when the
    // current one retires at this very edge.
    assign w_issue = (!r_pending || w_ack) && (w_occ_next < c_DEPTH);

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed; validity is tracked by the pointers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wptr[c_AW-1:0]]   <= r_mem_addr;
            r_fifo_insn[r_wptr[c_AW-1:0]] <= mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Control, memory request and decode output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= '0;
            r_pending  <= 1'b0;
            r_discard  <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_insn     <= c_NOP;
            r_insn_pc  <= '0;
        end else if (flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fetch_pc <= target;
            r_insn     <= c_NOP;
            r_insn_pc  <= target;
            if (r_pending && !mem_ack) begin
                // The request cannot be withdrawn: keep it on the bus and
                // throw its data away when it completes.
                r_discard <= 1'b1;
            end else begin
                // Nothing in flight (or its ack is dropped now): the FIFO is
                // empty after the flush, so the redirect fetch goes out at once.
                r_pending  <= 1'b1;
                r_mem_addr <= target;
                r_discard  <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + (c_AW + 1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (c_AW + 1)'(1);
            end

            r_fetch_pc <= w_fetch_pc_next;

            if (w_ack && r_discard) begin
                r_discard <= 1'b0;
            end

            if (w_issue) begin
                r_pending  <= 1'b1;
                r_mem_addr <= w_fetch_pc_next;
            end else if (w_ack) begin
                r_pending  <= 1'b0;
            end

            // Decode output: oldest buffered entry first, then a bypassed
            // response, otherwise a bubble with the last PC held.
            if (!stall) begin
                if (!w_empty) begin
                    r_insn    <= r_fifo_insn[r_rptr[c_AW-1:0]];
                    r_insn_pc <= r_fifo_pc[r_rptr[c_AW-1:0]];
                end else if (w_bypass) begin
                    r_insn    <= mem_data;
                    r_insn_pc <= r_mem_addr;
                end else begin
                    r_insn    <= c_NOP;
                end
            end
        end
    end

    assign insn     = r_insn;
    assign insn_pc  = r_insn_pc;
    assign mem_req  = r_pending;
    assign mem_addr = r_mem_addr;

endmodule
`default_nettype wire
